mux_sel_arbiter: RTL

- Two-source burst arbiter that sits directly upstream of the 2:1 data mux.
- Decides which of two requesters (port 0, port 1) owns the mux and drives `sel`.
- Also registers the selected data beat onto a single output stream.
- Uses round-robin fairness, burst locking via per-port `last`, and a hold-timeout so one source cannot starve the other.

---
 rtl/mux_sel_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mux_sel_arbiter.sv
// Two-source burst arbiter for a 2:1 data mux. Grants ownership with
// round-robin tie-breaking, locks the grant for a whole burst (ended by
// last_n), and forces a release after MAX_HOLD cycles while the other port
// is waiting. The selected beat is registered onto dout.
module mux_sel_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              last_0,
  input  logic [DATA_W-1:0] din_0,
  input  logic              req_1,
  input  logic              last_1,
  input  logic [DATA_W-1:0] din_1,
  output logic              grant_0,
  output logic              grant_1,
  output logic              sel,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              dout_last
);

  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGnt0,
    StGnt1
  } state_e;

  state_e              r_state, w_state_d;
  logic                r_sel, w_sel_d;
  logic                r_rr_last, w_rr_last_d;
  logic [HoldW-1:0]    r_hold_cnt, w_hold_cnt_d;
  logic [DATA_W-1:0]   r_dout, w_dout_d;
  logic                r_dout_valid, w_dout_valid_d;
  logic                r_dout_last, w_dout_last_d;
  logic                w_hold_max;
  logic                w_release;

  assign w_hold_max = (r_hold_cnt == HoldMax);

  // Next-state, grant bookkeeping and data-path capture.
  always_comb begin
    w_state_d      = r_state;
    w_sel_d        = r_sel;
    w_rr_last_d    = r_rr_last;
    w_hold_cnt_d   = r_hold_cnt;
    w_dout_d       = r_dout;
    w_dout_valid_d = 1'b0;
    w_dout_last_d  = 1'b0;
    w_release      = 1'b0;

    unique case (r_state)
      StIdle: begin
        // On a tie the port that was not served last wins.
        if (req_0 && (!req_1 || r_rr_last)) begin
          w_state_d    = StGnt0;
          w_sel_d      = 1'b0;
          w_hold_cnt_d = '0;
        end else if (req_1) begin
          w_state_d    = StGnt1;
          w_sel_d      = 1'b1;
          w_hold_cnt_d = '0;
        end
      end

      StGnt0: begin
        w_dout_d       = din_0;
        w_dout_valid_d = req_0;
        w_dout_last_d  = req_0 && last_0;
        w_release      = (req_0 && last_0) || !req_0 || (w_hold_max && req_1);
        if (w_release) begin
          w_rr_last_d = 1'b0;
          if (req_1) begin
            w_state_d    = StGnt1;
            w_sel_d      = 1'b1;
            w_hold_cnt_d = '0;
          end else begin
            w_state_d = StIdle;
          end
        end else if (!w_hold_max) begin
          // Saturate so an uncontended stream never wraps into a release.
          w_hold_cnt_d = r_hold_cnt + 1'b1;
        end
      end

      StGnt1: begin
        w_dout_d       = din_1;
        w_dout_valid_d = req_1;
        w_dout_last_d  = req_1 && last_1;
        w_release      = (req_1 && last_1) || !req_1 || (w_hold_max && req_0);
        if (w_release) begin
          w_rr_last_d = 1'b1;
          if (req_0) begin
            w_state_d    = StGnt0;
            w_sel_d      = 1'b0;
            w_hold_cnt_d = '0;
          end else begin
            w_state_d = StIdle;
          end
        end else if (!w_hold_max) begin
          w_hold_cnt_d = r_hold_cnt + 1'b1;
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State and output registers; rr_last resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_sel        <= 1'b0;
      r_rr_last    <= 1'b1;
      r_hold_cnt   <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_sel        <= w_sel_d;
      r_rr_last    <= w_rr_last_d;
      r_hold_cnt   <= w_hold_cnt_d;
      r_dout       <= w_dout_d;
      r_dout_valid <= w_dout_valid_d;
      r_dout_last  <= w_dout_last_d;
    end
  end

  assign grant_0    = (r_state == StGnt0);
  assign grant_1    = (r_state == StGnt1);
  assign sel        = r_sel;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign dout_last  = r_dout_last;

endmodule
